// File: rtl/axis_header_arbiter.sv
// Per-packet round-robin arbiter sharing one header-insertion stage among N_SRC requesters.
// A grant is held until the last beat of the owned packet is seen on the snooped stream.
module axis_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int N_SRC        = 4,
    parameter int SEL_WD       = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [N_SRC-1:0]                req_valid,
    input  logic [N_SRC*DATA_WD-1:0]        req_header,
    input  logic [N_SRC*DATA_BYTE_WD-1:0]   req_keep,
    output logic [N_SRC-1:0]                req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              header_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    input  logic                            ready_insert,
    input  logic                            snoop_valid,
    input  logic                            snoop_ready,
    input  logic                            snoop_last,
    output logic [SEL_WD-1:0]               grant_id,
    output logic                            busy,
    output logic                            pkt_done,
    output logic                            orphan_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [SEL_WD-1:0]        rr_ptr;
    logic [SEL_WD-1:0]        rr_ptr_next;
    logic                     valid_next;
    logic                     busy_next;
    logic                     done_next;
    logic                     orphan_next;
    logic [DATA_WD-1:0]       header_next;
    logic [DATA_BYTE_WD-1:0]  keep_next;
    logic [SEL_WD-1:0]        grant_next;

    logic                     last_beat;
    logic [2*N_SRC-1:0]       req_dbl;
    logic [N_SRC-1:0]         req_rot;
    logic                     found;
    logic [SEL_WD:0]          win_sum;
    logic [SEL_WD-1:0]        winner;
    logic                     take;
    logic [DATA_WD-1:0]       win_header;
    logic [DATA_BYTE_WD-1:0]  win_keep;
    logic [SEL_WD-1:0]        ptr_after;

    assign last_beat = snoop_valid & snoop_ready & snoop_last;

    // Rotate requests so bit 0 is the source at rr_ptr; the lowest set bit is the winner.
    assign req_dbl = {req_valid, req_valid};
    assign req_rot = N_SRC'(req_dbl >> rr_ptr);

    always_comb begin
        found   = 1'b0;
        win_sum = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                win_sum = {1'b0, rr_ptr} + (SEL_WD+1)'(k);
            end
        end
        if (win_sum >= (SEL_WD+1)'(N_SRC)) begin
            win_sum = win_sum - (SEL_WD+1)'(N_SRC);
        end
        winner = win_sum[SEL_WD-1:0];
    end

    // No new grant in the cycle pkt_done is showing; rst_n gating keeps req_ready low in reset.
    assign take = rst_n && (state == IDLE) && enable && found && !pkt_done;

    always_comb begin
        req_ready  = '0;
        win_header = '0;
        win_keep   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (winner == SEL_WD'(i)) begin
                win_header   = req_header[i*DATA_WD +: DATA_WD];
                win_keep     = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                req_ready[i] = take;
            end
        end
    end

    assign ptr_after = (grant_id == SEL_WD'(N_SRC - 1)) ? '0 : grant_id + SEL_WD'(1);

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        valid_next  = valid_insert;
        busy_next   = busy;
        header_next = header_insert;
        keep_next   = keep_insert;
        grant_next  = grant_id;
        done_next   = 1'b0;
        orphan_next = 1'b0;
        unique case (state)
            IDLE: begin
                orphan_next = last_beat;
                if (take) begin
                    header_next = win_header;
                    keep_next   = win_keep;
                    grant_next  = winner;
                    valid_next  = 1'b1;
                    busy_next   = 1'b1;
                    state_next  = OFFER;
                end
            end
            OFFER: begin
                // A last beat before the header is accepted belongs to no owned packet.
                if (ready_insert) begin
                    valid_next = 1'b0;
                    if (last_beat) begin
                        done_next   = 1'b1;
                        busy_next   = 1'b0;
                        rr_ptr_next = ptr_after;
                        state_next  = IDLE;
                    end else begin
                        state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (last_beat) begin
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    rr_ptr_next = ptr_after;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            valid_insert  <= 1'b0;
            header_insert <= '0;
            keep_insert   <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
            pkt_done      <= 1'b0;
            orphan_last   <= 1'b0;
        end else begin
            state         <= state_next;
            rr_ptr        <= rr_ptr_next;
            valid_insert  <= valid_next;
            header_insert <= header_next;
            keep_insert   <= keep_next;
            grant_id      <= grant_next;
            busy          <= busy_next;
            pkt_done      <= done_next;
            orphan_last   <= orphan_next;
        end
    end

endmodule

// File: tb/tb_axis_header_arbiter.sv
// Self-checking bench for axis_header_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a packet-level model.
module tb_axis_header_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_header = '0;
    logic [N*KW-1:0] req_keep = '0;
    logic [N-1:0]    req_ready;
    logic            valid_insert;
    logic [DW-1:0]   header_insert;
    logic [KW-1:0]   keep_insert;
    logic            ready_insert = 1'b0;
    logic            snoop_valid = 1'b0;
    logic            snoop_ready = 1'b0;
    logic            snoop_last = 1'b0;
    logic [SW-1:0]   grant_id;
    logic            busy;
    logic            pkt_done;
    logic            orphan_last;

    int tests_run  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    axis_header_arbiter #(
        .DATA_WD(DW), .DATA_BYTE_WD(KW), .N_SRC(N), .SEL_WD(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_header(req_header), .req_keep(req_keep),
        .req_ready(req_ready), .valid_insert(valid_insert),
        .header_insert(header_insert), .keep_insert(keep_insert),
        .ready_insert(ready_insert), .snoop_valid(snoop_valid),
        .snoop_ready(snoop_ready), .snoop_last(snoop_last),
        .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done),
        .orphan_last(orphan_last)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [N-1:0] rv, input logic ri,
                                 input logic sv, input logic sr, input logic sl);
        @(posedge clk);
        #1;
        enable       = en;
        req_valid    = rv;
        ready_insert = ri;
        snoop_valid  = sv;
        snoop_ready  = sr;
        snoop_last   = sl;
    endtask

    // Packet-level model: owner (-1 = nobody), whether the header is still on offer,
    // the round-robin start point, and the one-cycle pulses.
    int            m_owner  = -1;
    int            m_ptr    = 0;
    logic          m_valid  = 1'b0;
    logic          m_done   = 1'b0;
    logic          m_orphan = 1'b0;
    logic [DW-1:0] m_hdr    = '0;
    logic [KW-1:0] m_keep   = '0;
    int            win;
    logic [N-1:0]  exp_rdy;
    logic          lastb;
    logic          fin;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            checkOutput("rst_valid",  64'(valid_insert),  64'(0));
            checkOutput("rst_busy",   64'(busy),          64'(0));
            checkOutput("rst_ready",  64'(req_ready),     64'(0));
            checkOutput("rst_done",   64'(pkt_done),      64'(0));
            checkOutput("rst_orphan", 64'(orphan_last),   64'(0));
            checkOutput("rst_header", 64'(header_insert), 64'(0));
            m_owner  = -1;
            m_ptr    = 0;
            m_valid  = 1'b0;
            m_done   = 1'b0;
            m_orphan = 1'b0;
        end else begin
            win = -1;
            if (m_owner < 0 && enable && !m_done) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && ((req_valid >> ((m_ptr + k) % N)) & 4'd1) != 4'd0) begin
                        win = (m_ptr + k) % N;
                    end
                end
            end
            exp_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
            checkOutput("req_ready",    64'(req_ready),    64'(exp_rdy));
            checkOutput("valid_insert", 64'(valid_insert), 64'(m_valid));
            checkOutput("busy",         64'(busy),         64'(m_owner >= 0));
            checkOutput("pkt_done",     64'(pkt_done),     64'(m_done));
            checkOutput("orphan_last",  64'(orphan_last),  64'(m_orphan));
            if (m_valid) begin
                checkOutput("header_insert", 64'(header_insert), 64'(m_hdr));
                checkOutput("keep_insert",   64'(keep_insert),   64'(m_keep));
            end
            if (m_owner >= 0) begin
                checkOutput("grant_id", 64'(grant_id), 64'(m_owner));
            end

            lastb    = snoop_valid && snoop_ready && snoop_last;
            fin      = 1'b0;
            m_done   = 1'b0;
            m_orphan = 1'b0;
            if (m_owner < 0) begin
                m_orphan = lastb;
                if (win >= 0) begin
                    m_owner = win;
                    m_valid = 1'b1;
                    m_hdr   = DW'(req_header >> (win * DW));
                    m_keep  = KW'(req_keep >> (win * KW));
                end
            end else if (m_valid) begin
                if (ready_insert) begin
                    m_valid = 1'b0;
                    fin     = lastb;
                end
            end else begin
                fin = lastb;
            end
            if (fin) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_done  = 1'b1;
            end
        end
    end

    int grants[$];

    initial begin
        // Requests are presented during reset to show req_ready stays gated.
        enable     = 1'b1;
        req_valid  = 4'b1111;
        req_header = {32'h44444444, 32'h33333333, 32'h22222222, 32'hA1B2C3D4};
        req_keep   = {4'hF, 4'h0, 4'hF, 4'b0111};
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 64'(req_ready),   64'(0));
        checkOutput("reset_keep",      64'(keep_insert), 64'(0));
        checkOutput("reset_grant",     64'(grant_id),    64'(0));
        req_valid = '0;
        rst_n     = 1'b1;

        // Single request from source 0.
        applyStimulus(1, 4'b0001, 0, 0, 0, 0);
        #1 checkOutput("single_req_ready", 64'(req_ready), 64'(4'b0001));
        applyStimulus(1, 4'b0000, 1, 0, 0, 0);
        checkOutput("single_valid",  64'(valid_insert),  64'(1));
        checkOutput("single_header", 64'(header_insert), 64'(32'hA1B2C3D4));
        checkOutput("single_keep",   64'(keep_insert),   64'(4'b0111));
        checkOutput("single_grant",  64'(grant_id),      64'(0));
        applyStimulus(1, 4'b0000, 0, 0, 0, 0);
        checkOutput("single_hold_valid", 64'(valid_insert), 64'(0));
        checkOutput("single_hold_busy",  64'(busy),         64'(1));
        applyStimulus(1, 4'b0000, 0, 1, 1, 0);
        applyStimulus(1, 4'b0000, 0, 1, 1, 1);
        applyStimulus(1, 4'b0000, 0, 0, 0, 0);
        checkOutput("single_done", 64'(pkt_done), 64'(1));
        checkOutput("single_busy", 64'(busy),     64'(0));
        applyStimulus(1, 4'b1111, 0, 0, 0, 0);
        checkOutput("single_done_once", 64'(pkt_done), 64'(0));
        #1 checkOutput("single_rr_ptr1", 64'(req_ready), 64'(4'b0010));
        applyStimulus(1, 4'b0000, 1, 1, 1, 1);
        checkOutput("single_next_grant", 64'(grant_id), 64'(1));

        // Round robin with all sources requesting after a fresh reset.
        applyStimulus(1, 4'b0000, 0, 0, 0, 0);
        rst_n = 1'b0;
        applyStimulus(1, 4'b0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 40 && grants.size() < 5; cyc++) begin
            applyStimulus(1, 4'b1111, 1, 1, 1, 1);
            if (valid_insert) grants.push_back(int'(grant_id));
        end
        checkOutput("rr_count", 64'(grants.size()), 64'(5));
        foreach (grants[i]) begin
            checkOutput("rr_order", 64'(grants[i]), 64'(i % 4));
        end

        // Backpressure on source 2 with a last beat that must be ignored.
        applyStimulus(1, 4'b0000, 0, 0, 0, 0);
        applyStimulus(1, 4'b0100, 0, 0, 0, 0);
        #1 checkOutput("bp_req_ready", 64'(req_ready), 64'(4'b0100));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 4'b0000, 0, i == 2, i == 2, i == 2);
            checkOutput("bp_valid",  64'(valid_insert),  64'(1));
            checkOutput("bp_header", 64'(header_insert), 64'(32'h33333333));
            checkOutput("bp_keep",   64'(keep_insert),   64'(4'h0));
            checkOutput("bp_no_done", 64'(pkt_done),     64'(0));
        end
        applyStimulus(1, 4'b0000, 1, 0, 0, 0);
        applyStimulus(1, 4'b0000, 0, 1, 1, 1);
        checkOutput("bp_hold_valid", 64'(valid_insert), 64'(0));
        applyStimulus(1, 4'b0000, 0, 0, 0, 0);
        checkOutput("bp_done", 64'(pkt_done), 64'(1));

        // Header accepted together with the last beat in the first OFFER cycle.
        applyStimulus(1, 4'b1000, 0, 0, 0, 0);
        #1 checkOutput("sc_req_ready", 64'(req_ready), 64'(4'b1000));
        applyStimulus(1, 4'b1000, 1, 1, 1, 1);
        checkOutput("sc_grant", 64'(grant_id), 64'(3));
        #1 checkOutput("sc_offer_no_ready", 64'(req_ready), 64'(0));
        applyStimulus(1, 4'b1000, 0, 0, 0, 0);
        checkOutput("sc_done", 64'(pkt_done), 64'(1));
        checkOutput("sc_busy", 64'(busy),     64'(0));
        #1 checkOutput("sc_blocked", 64'(req_ready), 64'(0));
        applyStimulus(1, 4'b1000, 0, 0, 0, 0);
        #1 checkOutput("sc_next_accept", 64'(req_ready), 64'(4'b1000));
        applyStimulus(1, 4'b0000, 1, 1, 1, 1);
        applyStimulus(1, 4'b0000, 0, 0, 0, 0);

        // Enable low, orphan last beat in IDLE, then enable source 1.
        applyStimulus(0, 4'b0010, 0, 0, 0, 0);
        #1 checkOutput("en_off_ready", 64'(req_ready), 64'(0));
        applyStimulus(0, 4'b0010, 0, 1, 1, 1);
        applyStimulus(0, 4'b0010, 0, 0, 0, 0);
        checkOutput("orphan_pulse", 64'(orphan_last), 64'(1));
        checkOutput("orphan_idle",  64'(busy),        64'(0));
        applyStimulus(1, 4'b0010, 0, 0, 0, 0);
        checkOutput("orphan_once", 64'(orphan_last), 64'(0));
        #1 checkOutput("en_on_ready", 64'(req_ready), 64'(4'b0010));
        applyStimulus(1, 4'b0000, 1, 0, 0, 0);
        checkOutput("en_grant", 64'(grant_id), 64'(1));
        applyStimulus(1, 4'b0000, 0, 1, 1, 0);

        // Reset while in HOLD clears everything immediately.
        @(posedge clk);
        #1;
        enable    = 1'b1;
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        checkOutput("mid_rst_busy",   64'(busy),          64'(0));
        checkOutput("mid_rst_grant",  64'(grant_id),      64'(0));
        checkOutput("mid_rst_header", 64'(header_insert), 64'(0));
        checkOutput("mid_rst_ready",  64'(req_ready),     64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 checkOutput("mid_rst_prio0", 64'(req_ready), 64'(4'b0001));
        applyStimulus(1, 4'b0000, 1, 1, 1, 1);

        // Randomized traffic checked by the model on every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(($urandom_range(0, 9) != 0), 4'($urandom()),
                          1'($urandom()), 1'($urandom()), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) begin
                req_header = {$urandom(), $urandom(), $urandom(), $urandom()};
                req_keep   = 16'($urandom());
            end
            rst_n = ($urandom_range(0, 399) != 0);
        end

        applyStimulus(1, 4'b0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
